// File: rtl/ln_arbiter_pkg.sv
// Shared constants for the ln blocks: default sizing of the arbiter and its tag width.
package ln_arbiter_pkg;

    // Width of a requester index; never zero so a single requester still has a tag bit.
    function automatic int unsigned tag_width(int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned LnNumReq  = 4;
    localparam int unsigned LnLatency = 75;
    localparam int unsigned LnMaxOut  = 15;
    localparam int unsigned LnTagW    = tag_width(LnNumReq);

endpackage

// File: rtl/ln_rr_pick.sv
// Round-robin picker: first eligible requester at or after the pointer, as a one-hot grant.
module ln_rr_pick
    import ln_arbiter_pkg::*;
#(
    parameter int unsigned N = LnNumReq,
    localparam int unsigned PtrW = tag_width(N)
) (
    input  logic [N-1:0]    eligible_i,
    input  logic [PtrW-1:0] ptr_i,
    output logic [N-1:0]    grant_o
);

    logic            found;
    logic [PtrW-1:0] idx;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = '0;
        for (int unsigned i = 0; i < N; i++) begin
            idx = PtrW'((32'(ptr_i) + i) % N);
            if (!found && eligible_i[idx]) begin
                grant_o[idx] = 1'b1;
                found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ln_arbiter.sv
// Shares one pipelined ln core among NUM_REQ requesters with round-robin issue,
// per-requester credit limits and a tag pipeline that routes results back.
module ln_arbiter
    import ln_arbiter_pkg::*;
#(
    parameter int unsigned NUM_REQ = LnNumReq,
    parameter int unsigned LATENCY = LnLatency,
    parameter int unsigned MAX_OUT = LnMaxOut
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*32-1:0] req_x,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 core_start,
    output logic [31:0]          core_x,
    input  logic                 core_done,
    input  logic [31:0]          core_ln,
    input  logic                 core_error,
    output logic [NUM_REQ-1:0]   rsp_valid,
    output logic [31:0]          rsp_ln,
    output logic                 rsp_error,
    output logic [6:0]           in_flight,
    output logic                 proto_err
);

    localparam int unsigned TagW   = tag_width(NUM_REQ);
    localparam int unsigned CntW   = $clog2(MAX_OUT + 1);
    localparam int unsigned Depth  = LATENCY + 1;
    localparam int unsigned DrainW = $clog2(LATENCY + 2);

    logic [CntW-1:0]    outst_q [NUM_REQ];
    logic [CntW-1:0]    outst_d [NUM_REQ];
    logic [NUM_REQ-1:0] eligible, grant;
    logic [TagW-1:0]    ptr_q, grant_idx;
    logic [31:0]        sel_x;
    logic               xfer;

    logic               core_start_q;
    logic [31:0]        core_x_q;
    logic [Depth-1:0]   tag_v_q;
    logic [TagW-1:0]    tag_id_q [Depth];
    logic [DrainW-1:0]  drain_q;
    logic               drain_active, tag_hit, fire;

    logic [NUM_REQ-1:0] rsp_valid_q;
    logic [31:0]        rsp_ln_q;
    logic               rsp_err_q;
    logic [6:0]         in_flight_q;
    logic               proto_q;

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = req_valid[i] && (outst_q[i] < CntW'(MAX_OUT));
        end
    end

    ln_rr_pick #(
        .N(NUM_REQ)
    ) u_pick (
        .eligible_i(eligible),
        .ptr_i     (ptr_q),
        .grant_o   (grant)
    );

    assign req_ready = rst ? '0 : grant;
    assign xfer      = |req_ready;

    always_comb begin
        grant_idx = '0;
        sel_x     = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                grant_idx = TagW'(i);
                sel_x     = req_x[32*i +: 32];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            outst_d[i] = outst_q[i] + CntW'(req_ready[i]) - CntW'(rsp_valid_q[i]);
        end
    end

    // The last tag stage lines up with core_done for the issue LATENCY cycles earlier.
    assign drain_active = (drain_q != '0);
    assign tag_hit      = tag_v_q[Depth-1];
    assign fire         = core_done && tag_hit && !drain_active;

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q        <= '0;
            core_start_q <= 1'b0;
            core_x_q     <= '0;
            tag_v_q      <= '0;
            drain_q      <= DrainW'(LATENCY + 1);
            rsp_valid_q  <= '0;
            rsp_ln_q     <= '0;
            rsp_err_q    <= 1'b0;
            in_flight_q  <= '0;
            proto_q      <= 1'b0;
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                outst_q[i] <= '0;
            end
        end else begin
            core_start_q <= xfer;
            if (xfer) begin
                core_x_q <= sel_x;
                ptr_q    <= (grant_idx == TagW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            end
            tag_v_q <= {tag_v_q[Depth-2:0], xfer};
            if (drain_active) begin
                drain_q <= drain_q - 1'b1;
            end
            rsp_valid_q <= fire ? (NUM_REQ'(1) << tag_id_q[Depth-1]) : '0;
            if (fire) begin
                rsp_ln_q  <= core_ln;
                rsp_err_q <= core_error;
            end
            if (!drain_active && (core_done != tag_hit)) begin
                proto_q <= 1'b1;
            end
            in_flight_q <= in_flight_q + 7'(xfer) - 7'(|rsp_valid_q);
            for (int unsigned i = 0; i < NUM_REQ; i++) begin
                outst_q[i] <= outst_d[i];
            end
        end
    end

    // Tag indices are qualified by tag_v_q, so they need no reset.
    always_ff @(posedge clk) begin
        tag_id_q[0] <= grant_idx;
        for (int unsigned j = 1; j < Depth; j++) begin
            tag_id_q[j] <= tag_id_q[j-1];
        end
    end

    assign core_start = core_start_q;
    assign core_x     = core_x_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_ln     = rsp_ln_q;
    assign rsp_error  = rsp_err_q;
    assign in_flight  = in_flight_q;
    assign proto_err  = proto_q;

endmodule

// File: doc/ln_arbiter.md
LN_ARBITER -- requirements
Module: ln_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requesters sharing one ln_fast_core.
REQ-002 Parameter LATENCY, default 75: core cycles from core_start to core_done.
REQ-003 Parameter MAX_OUT, default 15: maximum outstanding operations per requester.
REQ-004 clk  in  1  sole clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 req_valid  in  NUM_REQ  per-requester operand valid.
REQ-007 req_x  in  NUM_REQ*32  per-requester IEEE-754 single operand; requester i occupies bits [32i+31:32i].
REQ-008 req_ready  out  NUM_REQ  per-requester accept; a transfer occurs when req_valid[i] and req_ready[i] are both high.
REQ-009 core_start, core_x  out  1, 32  issue port to ln_fast_core start and x.
REQ-010 core_done, core_ln, core_error  in  1, 32, 1  return port from ln_fast_core.
REQ-011 rsp_valid  out  NUM_REQ  one-hot result strobe; no backpressure.
REQ-012 rsp_ln, rsp_error  out  32, 1  shared result bus, qualified by rsp_valid.
REQ-013 in_flight  out  7  total operations issued and not yet returned.
REQ-014 proto_err  out  1  sticky core-protocol violation flag.

Function
REQ-015 Requester i is eligible when req_valid[i]=1 and outstanding[i] < MAX_OUT.
REQ-016 The arbiter grants at most one eligible requester per cycle, round-robin; search starts at the index after the last granted requester.
REQ-017 req_ready is combinational from the grant; req_ready[i] is never high for an ineligible requester.
REQ-018 A transfer in cycle T drives core_start=1 and core_x=accepted operand in T+1 (registered); otherwise core_start=0 and core_x holds.
REQ-019 The arbiter keeps a LATENCY+1 deep tag pipeline (valid plus requester index) aligned so the tag for the T+1 issue is presented when core_done arrives at T+1+LATENCY.
REQ-020 On core_done with a valid aligned tag k, the arbiter registers the result: in the next cycle rsp_valid[k]=1, rsp_ln=core_ln, rsp_error=core_error; handshake-to-response latency is LATENCY+2.
REQ-021 outstanding[i] increments on a transfer and decrements on rsp_valid[i]; simultaneous increment and decrement leaves it unchanged.
REQ-022 in_flight equals the sum of outstanding[] and follows the same simultaneous-event rule.
REQ-023 proto_err sets on core_done with no valid aligned tag, or on a valid aligned tag without core_done, outside the drain window; it clears only on rst.
REQ-024 Drain window: for LATENCY+1 cycles after rst deasserts, core_done is ignored (no rsp_valid, no proto_err); grants proceed normally during the window.
REQ-025 rsp_valid is all-zero in any cycle with no returning tagged result.

Reset
REQ-026 On rst: req_ready=0, core_start=0, core_x=0, rsp_valid=0, rsp_ln=0, rsp_error=0, in_flight=0, proto_err=0, every outstanding[i]=0, all tags invalid, round-robin pointer selects requester 0 first, drain counter loaded with LATENCY+1.
REQ-027 Reset mid-operation discards all in-flight work; no response is delivered for operations accepted before reset.

Structure
REQ-028 NUM_REQ, LATENCY, MAX_OUT defaults and the derived tag width (clog2 NUM_REQ) live in the shared constants include used by the ln blocks.
REQ-029 Round-robin selection is a sub-module, ln_rr_pick (eligible vector plus pointer in, one-hot grant out); ln_fast_core is not instantiated inside ln_arbiter.

Verification
REQ-030 Requester 2 sends x=0x3f000000, handshake at cycle 10 -> core_start=1 and core_x=0x3f000000 at 11; model core_done at 86 -> rsp_valid=4'b0100 and rsp_ln=model value at 87.
REQ-031 All four req_valid held high from reset -> grants 0,1,2,3,0,1,... one per cycle; core_start high every cycle; in_flight reaches 60 and saturates.
REQ-032 Requester 1 alone offers 16 back-to-back operands -> 15 accepted, req_ready[1]=0 afterwards, 16th accepted the cycle after the first rsp_valid[1].
REQ-033 Transfer and response for requester 0 in the same cycle -> outstanding[0] and in_flight unchanged.
REQ-034 rst asserted with 10 operations in flight -> no rsp_valid ever appears for them, proto_err stays 0 through the 76-cycle drain window; an unsolicited core_done at drain+5 -> proto_err=1 and it holds.
REQ-035 x=0x3fc00000 with model core_error=1 -> rsp_error=1 coincident with the requester's rsp_valid.
